// File: rtl/ttt_turn_sequencer.sv
// ttt_turn_sequencer: turn controller in front of the tic_tac_toe_game core.
// Enforces player/computer alternation and square legality, strobes the core,
// tracks the board and move count, and declares win/draw from the core's who.
module ttt_turn_sequencer #(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CPU_TIMEOUT   = 255,
  parameter bit          PLAYER_FIRST  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       player_req,
  input  logic [3:0] player_sel,
  input  logic       cpu_req,
  input  logic [3:0] cpu_sel,
  input  logic [1:0] who,
  output logic       play,
  output logic       pc,
  output logic [3:0] player_position,
  output logic [3:0] computer_position,
  output logic       turn,
  output logic       illegal,
  output logic       game_over,
  output logic [1:0] result,
  output logic [3:0] moves,
  output logic [8:0] occupied
);

  localparam int unsigned MAX_PS  = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_PS > CPU_TIMEOUT) ? MAX_PS : CPU_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    WAIT_P  = 3'd0,
    ISSUE_P = 3'd1,
    SETTLE  = 3'd2,
    WAIT_C  = 3'd3,
    ISSUE_C = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               play_nxt;
  logic               pc_nxt;
  logic [3:0]         player_position_nxt;
  logic [3:0]         computer_position_nxt;
  logic               turn_nxt;
  logic               illegal_nxt;
  logic               game_over_nxt;
  logic [1:0]         result_nxt;
  logic [3:0]         moves_nxt;
  logic [8:0]         occupied_nxt;

  logic [15:0]        occ_ext;
  logic               p_ok;
  logic               c_ok;
  logic               pulse_end;
  logic               settle_end;
  logic               timeout;
  logic               winner;
  logic [3:0]         free_idx;
  logic [3:0]         moves_inc;

  // Request legality, phase-end flags and saturating move increment
  always_comb begin
    occ_ext    = {7'b0, occupied};
    p_ok       = player_req && (player_sel <= 4'd8) && !occ_ext[player_sel];
    c_ok       = cpu_req && (cpu_sel <= 4'd8) && !occ_ext[cpu_sel];
    pulse_end  = (cnt == CNT_W'(PULSE_CYCLES - 1));
    settle_end = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    timeout    = (cnt == CNT_W'(CPU_TIMEOUT - 1));
    winner     = (who == 2'b01) || (who == 2'b10);
    moves_inc  = (moves >= 4'd9) ? 4'd9 : moves + 4'd1;
  end

  // Lowest-index free square for the computer auto-move
  always_comb begin
    free_idx = 4'd0;
    for (int k = 8; k >= 0; k--) begin
      if (!occupied[k]) free_idx = 4'(k);
    end
  end

  // State register plus registered outputs; reset and new_game restart the game
  always_ff @(posedge clock) begin
    if (reset || new_game) begin
      state             <= PLAYER_FIRST ? WAIT_P : WAIT_C;
      cnt               <= '0;
      play              <= 1'b0;
      pc                <= 1'b0;
      player_position   <= 4'd0;
      computer_position <= 4'd0;
      turn              <= ~PLAYER_FIRST;
      illegal           <= 1'b0;
      game_over         <= 1'b0;
      result            <= 2'b00;
      moves             <= 4'd0;
      occupied          <= 9'd0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      play              <= play_nxt;
      pc                <= pc_nxt;
      player_position   <= player_position_nxt;
      computer_position <= computer_position_nxt;
      turn              <= turn_nxt;
      illegal           <= illegal_nxt;
      game_over         <= game_over_nxt;
      result            <= result_nxt;
      moves             <= moves_nxt;
      occupied          <= occupied_nxt;
    end
  end

  // Next-state and phase counter; counter restarts on every state change
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_P:  if (p_ok) state_nxt = ISSUE_P;
      ISSUE_P: if (pulse_end) state_nxt = SETTLE;
      SETTLE: begin
        if (settle_end) begin
          if (winner || (moves == 4'd9)) state_nxt = DONE;
          else if (turn)                 state_nxt = WAIT_P;
          else                           state_nxt = WAIT_C;
        end
      end
      WAIT_C:  if (c_ok || timeout) state_nxt = ISSUE_C;
      ISSUE_C: if (pulse_end) state_nxt = SETTLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = PLAYER_FIRST ? WAIT_P : WAIT_C;
    endcase

    cnt_nxt = '0;
    if ((state_nxt == state) &&
        ((state == ISSUE_P) || (state == ISSUE_C) || (state == SETTLE) || (state == WAIT_C))) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Output next values: strobes, latched positions, board, result
  always_comb begin
    play_nxt              = play;
    pc_nxt                = pc;
    player_position_nxt   = player_position;
    computer_position_nxt = computer_position;
    turn_nxt              = turn;
    illegal_nxt           = 1'b0;
    game_over_nxt         = game_over;
    result_nxt            = result;
    moves_nxt             = moves;
    occupied_nxt          = occupied;
    case (state)
      WAIT_P: begin
        if (p_ok) begin
          play_nxt            = 1'b1;
          player_position_nxt = player_sel;
          occupied_nxt        = occupied | (9'(1) << player_sel);
          moves_nxt           = moves_inc;
        end else if (player_req) begin
          illegal_nxt = 1'b1;
        end
      end
      WAIT_C: begin
        if (c_ok) begin
          pc_nxt                = 1'b1;
          computer_position_nxt = cpu_sel;
          occupied_nxt          = occupied | (9'(1) << cpu_sel);
          moves_nxt             = moves_inc;
        end else begin
          if (cpu_req) illegal_nxt = 1'b1;
          if (timeout) begin
            pc_nxt                = 1'b1;
            computer_position_nxt = free_idx;
            occupied_nxt          = occupied | (9'(1) << free_idx);
            moves_nxt             = moves_inc;
          end
        end
      end
      ISSUE_P: if (pulse_end) play_nxt = 1'b0;
      ISSUE_C: if (pulse_end) pc_nxt = 1'b0;
      SETTLE: begin
        if (settle_end) begin
          if (winner) begin
            result_nxt    = who;
            game_over_nxt = 1'b1;
          end else if (moves == 4'd9) begin
            result_nxt    = 2'b11;
            game_over_nxt = 1'b1;
          end else begin
            turn_nxt = ~turn;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
